// File: rtl/bp_cache_dma_responder.sv
// Memory-side endpoint for the bsg_cache DMA interface: accepts block packets and
// streams fill beats out of (read) or into (write) an internal single-port SRAM.
module bp_cache_dma_responder #(
    parameter int addr_width_p          = 28,
    parameter int data_width_p          = 64,
    parameter int block_size_in_words_p = 8,
    parameter int dma_data_width_p      = 64,
    parameter int mem_els_p             = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [addr_width_p:0]       dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0] dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0] dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o
);
    localparam int beats_lp    = block_size_in_words_p * data_width_p / dma_data_width_p;
    localparam int beat_off_lp = $clog2(dma_data_width_p / 8);
    localparam int idx_w_lp    = $clog2(mem_els_p);
    localparam int cnt_w_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_lp - 1);
    localparam logic [idx_w_lp-1:0] blk_mask_lp = ~idx_w_lp'(beats_lp - 1);

    typedef enum logic [1:0] {
        e_ready,
        e_read_issue,
        e_read_resp,
        e_write
    } state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [idx_w_lp-1:0]   base_q, base_d;

    logic [addr_width_p-1:0]     pkt_beat;
    logic [idx_w_lp-1:0]         pkt_base;
    logic [idx_w_lp-1:0]         sram_idx;
    logic                        sram_v, sram_w;
    logic [dma_data_width_p-1:0] rdata_q;
    logic [dma_data_width_p-1:0] mem_q [mem_els_p];
    logic                        unused_pkt_bits;

    // Upper beat-index bits are dropped, so the address space aliases modulo mem_els_p beats.
    assign pkt_beat        = dma_pkt_i[addr_width_p-1:0] >> beat_off_lp;
    assign pkt_base        = pkt_beat[idx_w_lp-1:0] & blk_mask_lp;
    assign sram_idx        = base_q + idx_w_lp'(cnt_q);
    assign unused_pkt_bits = ^{pkt_beat, dma_pkt_i};
    assign dma_data_o      = rdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Handshakes: a beat or packet moves on a cycle where valid and ready/yumi are both high.
    // The read SRAM is only enabled in e_read_issue so rdata_q holds while the cache stalls.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        sram_v          = 1'b0;
        sram_w          = 1'b0;
        if (!reset_i) begin
            case (state_q)
                e_ready: begin
                    dma_pkt_yumi_o = dma_pkt_v_i;
                    if (dma_pkt_v_i) begin
                        base_d  = pkt_base;
                        cnt_d   = '0;
                        state_d = dma_pkt_i[addr_width_p] ? e_write : e_read_issue;
                    end
                end
                e_read_issue: begin
                    sram_v  = 1'b1;
                    state_d = e_read_resp;
                end
                e_read_resp: begin
                    dma_data_v_o = 1'b1;
                    if (dma_data_ready_and_i) begin
                        if (cnt_q == last_cnt_lp) begin
                            state_d = e_ready;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = e_read_issue;
                        end
                    end
                end
                e_write: begin
                    dma_data_yumi_o = dma_data_v_i;
                    if (dma_data_v_i) begin
                        sram_v = 1'b1;
                        sram_w = 1'b1;
                        if (cnt_q == last_cnt_lp) begin
                            state_d = e_ready;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = e_ready;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (sram_v) begin
            if (sram_w) begin
                mem_q[sram_idx] <= dma_data_i;
            end else begin
                rdata_q <= mem_q[sram_idx];
            end
        end
    end

endmodule

// File: tb/tb_bp_cache_dma_responder.sv
// Randomized bench for bp_cache_dma_responder against a flat array model of the
// block-addressed backing store.
module tb_bp_cache_dma_responder;
    localparam int AW      = 28;
    localparam int DW      = 64;
    localparam int BEATS   = 8;
    localparam int MEM_ELS = 1024;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [AW:0]   dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_and_i;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_yumi_o;

    always #5 clk = ~clk;

    bp_cache_dma_responder dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o)
    );

    logic [DW-1:0] model_mem [MEM_ELS];
    logic [DW-1:0] wbuf [BEATS];
    int n_checks = 0;
    int n_pass   = 0;

    // Block base in beats: byte address to beat, wrap to memory depth, round down to a block.
    function automatic int blk_base(input logic [AW-1:0] addr);
        int beat;
        beat = int'(addr / 8);
        return ((beat % MEM_ELS) / BEATS) * BEATS;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_pkt(input bit wnr, input logic [AW-1:0] addr);
        bit ok;
        ok = 1'b0;
        dma_pkt_i   = {wnr, addr};
        dma_pkt_v_i = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            #1;
            ok = (dma_pkt_yumi_o === 1'b1);
            @(posedge clk); #1;
        end
        dma_pkt_v_i = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL pkt_accept addr=%h: got no yumi, required yumi", addr);
        else n_pass++;
    endtask

    // mode 0: always ready, 1: random ready, 2: five-cycle stall on beat 3
    task automatic read_body(input logic [AW-1:0] addr, input int mode, input int n_beats);
        int base, beat, cyc, first_v, last_hs, stall_left, n_hold;
        bit held_f;
        logic [DW-1:0] held_d;
        base = blk_base(addr);
        beat = 0; cyc = 1; first_v = -1; last_hs = -1; stall_left = 5; n_hold = 0;
        held_f = 1'b0; held_d = '0;
        while (beat < n_beats && cyc < 400) begin
            if (dma_data_v_o === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (mode == 0) dma_data_ready_and_i = 1'b1;
                else if (mode == 1) dma_data_ready_and_i = 1'($urandom_range(0, 1));
                else begin
                    dma_data_ready_and_i = !(beat == 3 && stall_left > 0);
                    if (beat == 3 && stall_left > 0) stall_left--;
                end
            end else begin
                dma_data_ready_and_i = 1'($urandom_range(0, 1));
            end
            #1;
            if (held_f) begin
                n_hold++;
                n_checks++;
                if (dma_data_v_o !== 1'b1 || dma_data_o !== held_d)
                    $display("FAIL bp_hold beat=%0d: v=%b data=%h, required v=1 data=%h",
                             beat, dma_data_v_o, dma_data_o, held_d);
                else n_pass++;
            end
            held_f = 1'b0;
            if (dma_data_v_o === 1'b1 && dma_data_ready_and_i) begin
                n_checks++;
                if (dma_data_o !== model_mem[base + beat])
                    $display("FAIL rd_data addr=%h beat=%0d: got %h, required %h",
                             addr, beat, dma_data_o, model_mem[base + beat]);
                else n_pass++;
                beat++;
                last_hs = cyc;
            end else if (dma_data_v_o === 1'b1) begin
                held_f = 1'b1;
                held_d = dma_data_o;
            end
            @(posedge clk); #1;
            cyc++;
        end
        dma_data_ready_and_i = 1'b0;
        n_checks++;
        if (beat != n_beats) $display("FAIL rd_beats addr=%h: got %0d, required %0d", addr, beat, n_beats);
        else n_pass++;
        n_checks++;
        if (first_v != 2) $display("FAIL rd_latency: first valid at cycle %0d, required 2", first_v);
        else n_pass++;
        if (mode == 0 && n_beats == BEATS) begin
            n_checks++;
            if (last_hs != 2 * BEATS) $display("FAIL rd_block_time: last beat at %0d, required %0d", last_hs, 2 * BEATS);
            else n_pass++;
        end
        if (mode == 2) begin
            n_checks++;
            if (n_hold != 5) $display("FAIL bp_stall_count: got %0d held cycles, required 5", n_hold);
            else n_pass++;
        end
    endtask

    // Writes wbuf; with busy a read packet for the same block is offered throughout.
    task automatic write_body(input logic [AW-1:0] addr, input bit gapped, input bit busy);
        int base, beat, cyc, last_y;
        base = blk_base(addr);
        beat = 0; cyc = 1; last_y = -1;
        while (beat < BEATS && cyc < 400) begin
            dma_data_v_i = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            dma_data_i   = dma_data_v_i ? wbuf[beat] : {$urandom, $urandom};
            if (busy) begin
                dma_pkt_i   = {1'b0, addr};
                dma_pkt_v_i = 1'b1;
            end
            #1;
            n_checks++;
            if (dma_data_yumi_o !== dma_data_v_i)
                $display("FAIL wr_yumi beat=%0d: got %b, required %b", beat, dma_data_yumi_o, dma_data_v_i);
            else n_pass++;
            if (busy) begin
                n_checks++;
                if (dma_pkt_yumi_o !== 1'b0) $display("FAIL busy_pkt_yumi beat=%0d: got %b, required 0", beat, dma_pkt_yumi_o);
                else n_pass++;
            end
            if (dma_data_v_i) begin
                model_mem[base + beat] = wbuf[beat];
                beat++;
                last_y = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (beat != BEATS) $display("FAIL wr_beats addr=%h: got %0d, required %0d", addr, beat, BEATS);
        else n_pass++;
        if (!gapped) begin
            n_checks++;
            if (last_y != BEATS) $display("FAIL wr_block_time: last yumi at %0d, required %0d", last_y, BEATS);
            else n_pass++;
        end
        dma_data_v_i = 1'b1;
        #1;
        n_checks++;
        if (dma_data_yumi_o !== 1'b0) $display("FAIL wr_extra_yumi: got %b, required 0", dma_data_yumi_o);
        else n_pass++;
        dma_data_v_i = 1'b0;
        if (busy) begin
            n_checks++;
            if (dma_pkt_yumi_o !== 1'b1) $display("FAIL busy_accept_after_last: got %b, required 1", dma_pkt_yumi_o);
            else n_pass++;
        end
        @(posedge clk); #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        dma_pkt_i = {1'b1, 28'h40};
        dma_pkt_v_i = 1'b1;
        dma_data_v_i = 1'b1;
        dma_data_i = '0;
        dma_data_ready_and_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            n_checks++;
            if ({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o} !== 3'b000)
                $display("FAIL reset_outputs cycle=%0d: got %b, required 000", c,
                         {dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o});
            else n_pass++;
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        dma_data_v_i = 1'b0;
        dma_data_ready_and_i = 1'b0;
        #1;
        n_checks++;
        if (dma_pkt_yumi_o !== 1'b1) $display("FAIL reset_first_yumi: got %b, required 1", dma_pkt_yumi_o);
        else n_pass++;
        dma_pkt_v_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        for (int i = 0; i < BEATS; i++) wbuf[i] = DW'(64'h1000 + i);
        send_pkt(1'b1, 28'h40);
        write_body(28'h40, 1'b0, 1'b0);
        send_pkt(1'b0, 28'h40);
        read_body(28'h40, 0, BEATS);
    endtask

    task automatic test_backpressure();
        send_pkt(1'b0, 28'h40);
        read_body(28'h40, 2, BEATS);
    endtask

    task automatic test_alias();
        for (int i = 0; i < BEATS; i++) wbuf[i] = {$urandom, $urandom};
        send_pkt(1'b1, 28'h48);
        write_body(28'h48, 1'b0, 1'b0);
        send_pkt(1'b0, 28'h40);
        read_body(28'h40, 0, BEATS);
        send_pkt(1'b0, 28'h40 + MEM_ELS * 8);
        read_body(28'h40 + MEM_ELS * 8, 0, BEATS);
    endtask

    task automatic test_busy();
        for (int i = 0; i < BEATS; i++) wbuf[i] = {$urandom, $urandom};
        send_pkt(1'b1, 28'h80);
        write_body(28'h80, 1'b1, 1'b1);
        read_body(28'h80, 1, BEATS);
    endtask

    task automatic test_reset_mid_read();
        send_pkt(1'b0, 28'h40);
        read_body(28'h40, 0, 3);
        reset_i = 1'b1;
        dma_pkt_v_i = 1'b1;
        dma_pkt_i = {1'b0, 28'h40};
        dma_data_ready_and_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        dma_pkt_v_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (dma_data_v_o !== 1'b0) $display("FAIL reset_mid_read cycle=%0d: v=%b, required 0", c, dma_data_v_o);
            else n_pass++;
            @(posedge clk); #1;
        end
        dma_data_ready_and_i = 1'b0;
        send_pkt(1'b0, 28'h40);
        read_body(28'h40, 0, BEATS);
    endtask

    task automatic test_random();
        logic [AW-1:0] waddr, raddr;
        for (int it = 0; it < 8; it++) begin
            waddr = AW'($urandom);
            for (int i = 0; i < BEATS; i++) wbuf[i] = {$urandom, $urandom};
            send_pkt(1'b1, waddr);
            write_body(waddr, 1'b1, 1'b0);
            raddr = waddr ^ AW'($urandom << 13);
            raddr[5:0] = 6'($urandom);
            send_pkt(1'b0, raddr);
            read_body(raddr, 1, BEATS);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_alias();
        test_busy();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
